// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: branch/jump resolution, handshaked word load/store with
// bounded wait and stall request, and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Ctl_MemtoReg_in,
  input  logic        Ctl_RegWrite_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        Ctl_Branch_in,
  input  logic        Zero_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic [4:0]  Rd_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] PCimm_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] PC_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        PCSrc,
  output logic [31:0] PCtarget,
  output logic        flush_out,
  output logic        stall_out,
  output logic [31:0] mem_data,
  output logic        Ctl_MemtoReg_out,
  output logic        Ctl_RegWrite_out,
  output logic [4:0]  Rd_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUresult_out,
  output logic        mem_error,
  output logic [31:0] stall_count
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          mem_op, last_wait, read_done, forced_done;

  // Memory port, stall and branch resolution are all combinational
  always_comb begin
    mem_op      = Ctl_MemRead_in | Ctl_MemWrite_in;
    dmem_req    = reset & mem_op;
    dmem_we     = Ctl_MemWrite_in;
    dmem_addr   = ALUresult_in;
    dmem_wdata  = ReadData2_in;
    mem_data    = ALUresult_in;
    last_wait   = (state == WAIT) && (wait_cnt == LAST_WAIT);
    stall_out   = dmem_req & ~dmem_ready & ~last_wait;
    forced_done = dmem_req & ~dmem_ready & last_wait;
    // Both read and write set is a write: no load data returned
    read_done   = dmem_req & dmem_ready & Ctl_MemRead_in & ~Ctl_MemWrite_in;
    PCSrc       = (Ctl_Branch_in & Zero_in) | jal_in | jalr_in;
    PCtarget    = jalr_in ? {ALUresult_in[31:1], 1'b0} : PCimm_in;
    flush_out   = PCSrc;
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (dmem_req && !dmem_ready) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = CW'(1);
        end
      end
      WAIT: begin
        if (!dmem_req || dmem_ready || last_wait) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // MEM/WB register; a stalled cycle writes a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      Rd_out           <= '0;
      ReadData_out     <= '0;
      ALUresult_out    <= '0;
    end else if (stall_out) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
    end else begin
      Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
      Ctl_RegWrite_out <= Ctl_RegWrite_in;
      Rd_out           <= Rd_in;
      ReadData_out     <= read_done ? dmem_rdata : 32'd0;
      ALUresult_out    <= (jal_in | jalr_in) ? PC_in + 32'd4 : ALUresult_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_error   <= 1'b0;
      stall_count <= '0;
    end else begin
      if (forced_done) mem_error <= 1'b1;
      if (stall_out && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table plus wait/timeout/reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memtoreg, regwrite, memread, memwrite, branch, zero, jal, jalr;
  logic [4:0]  rd;
  logic [31:0] alu, pcimm, rd2, pc;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        PCSrc, flush_out, stall_out;
  logic [31:0] PCtarget, mem_data;
  logic        memtoreg_o, regwrite_o;
  logic [4:0]  rd_o;
  logic [31:0] readdata_o, alu_o;
  logic        mem_error;
  logic [31:0] stall_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .Ctl_MemtoReg_in(memtoreg), .Ctl_RegWrite_in(regwrite),
    .Ctl_MemRead_in(memread), .Ctl_MemWrite_in(memwrite),
    .Ctl_Branch_in(branch), .Zero_in(zero), .jal_in(jal), .jalr_in(jalr),
    .Rd_in(rd), .ALUresult_in(alu), .PCimm_in(pcimm), .ReadData2_in(rd2), .PC_in(pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .PCSrc(PCSrc), .PCtarget(PCtarget), .flush_out(flush_out), .stall_out(stall_out),
    .mem_data(mem_data),
    .Ctl_MemtoReg_out(memtoreg_o), .Ctl_RegWrite_out(regwrite_o), .Rd_out(rd_o),
    .ReadData_out(readdata_o), .ALUresult_out(alu_o),
    .mem_error(mem_error), .stall_count(stall_count)
  );

  typedef struct {
    logic        mr, mw, m2r, rw, br, z, jl, jr, rdy;
    logic [4:0]  rd;
    logic [31:0] alu, pcimm, rd2, pc, rdata;
    logic        e_pcsrc, e_req, e_we, e_rw, e_m2r;
    logic [31:0] e_tgt, e_rdat, e_alu;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memtoreg = 0; regwrite = 0; memread = 0; memwrite = 0; branch = 0; zero = 0;
    jal = 0; jalr = 0; rd = 0; alu = 0; pcimm = 0; rd2 = 0; pc = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  function automatic vec_t mk(logic mr, logic mw, logic m2r, logic rw, logic br, logic z,
                              logic jl, logic jr, logic rdy, logic [4:0] r, logic [31:0] a,
                              logic [31:0] pi, logic [31:0] d2, logic [31:0] p, logic [31:0] rdat,
                              logic epc, logic [31:0] etgt, logic ereq, logic ewe, logic erw,
                              logic em2r, logic [4:0] erd, logic [31:0] erdat, logic [31:0] ealu);
    vec_t v;
    v.mr = mr; v.mw = mw; v.m2r = m2r; v.rw = rw; v.br = br; v.z = z; v.jl = jl; v.jr = jr;
    v.rdy = rdy; v.rd = r; v.alu = a; v.pcimm = pi; v.rd2 = d2; v.pc = p; v.rdata = rdat;
    v.e_pcsrc = epc; v.e_tgt = etgt; v.e_req = ereq; v.e_we = ewe; v.e_rw = erw;
    v.e_m2r = em2r; v.e_rd = erd; v.e_rdat = erdat; v.e_alu = ealu;
    return v;
  endfunction

  // Count stalled cycles of a held request until it completes (bounded)
  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall_out) break;
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    //            mr mw m2r rw br z jl jr rdy rd  alu           pcimm         rd2           pc            rdata
    //            pcsrc tgt        req we rw_o m2r_o rd_o rdata_o       alu_o
    vecs[0] = mk(1,0,1,1,0,0,0,0,1, 5, 32'h100,      32'h0,        32'h0,        32'h0,        32'hDEADBEEF,
                 0, 32'h0,      1, 0, 1, 1, 5, 32'hDEADBEEF, 32'h100);
    vecs[1] = mk(0,0,0,1,0,0,0,0,0, 7, 32'h55,       32'h0,        32'h0,        32'h0,        32'hFFFF,
                 0, 32'h0,      0, 0, 1, 0, 7, 32'h0,        32'h55);
    vecs[2] = mk(0,0,0,0,1,1,0,0,0, 0, 32'h0,        32'h40,       32'h0,        32'h0,        32'h0,
                 1, 32'h40,     0, 0, 0, 0, 0, 32'h0,        32'h0);
    vecs[3] = mk(0,0,0,0,1,0,0,0,0, 3, 32'h9,        32'h40,       32'h0,        32'h0,        32'h0,
                 0, 32'h40,     0, 0, 0, 0, 3, 32'h0,        32'h9);
    vecs[4] = mk(0,0,0,1,0,0,0,1,0, 1, 32'h203,      32'h999,      32'h0,        32'h80,       32'h0,
                 1, 32'h202,    0, 0, 1, 0, 1, 32'h0,        32'h84);
    vecs[5] = mk(0,0,0,1,0,0,1,0,0, 2, 32'h7,        32'h1000,     32'h0,        32'hFFFFFFFC, 32'h0,
                 1, 32'h1000,   0, 0, 1, 0, 2, 32'h0,        32'h0);
    vecs[6] = mk(1,1,0,0,0,0,0,0,1, 4, 32'h300,      32'h0,        32'h77,       32'h0,        32'hAAAA,
                 0, 32'h0,      1, 1, 0, 0, 4, 32'h0,        32'h300);
    vecs[7] = mk(0,1,0,0,0,0,0,0,1, 0, 32'h104,      32'h0,        32'h12345678, 32'h0,        32'h5A5A,
                 0, 32'h0,      1, 1, 0, 0, 0, 32'h0,        32'h104);

    idle_inputs();
    reset = 0;
    memread = 1;
    #3;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    check("rst_regwrite", 32'(regwrite_o), 32'd0);
    check("rst_readdata", readdata_o, 32'd0);
    check("rst_stallcnt", stall_count, 32'd0);
    check("rst_memerr", 32'(mem_error), 32'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      memread = vecs[i].mr; memwrite = vecs[i].mw; memtoreg = vecs[i].m2r; regwrite = vecs[i].rw;
      branch = vecs[i].br; zero = vecs[i].z; jal = vecs[i].jl; jalr = vecs[i].jr;
      dmem_ready = vecs[i].rdy; rd = vecs[i].rd; alu = vecs[i].alu; pcimm = vecs[i].pcimm;
      rd2 = vecs[i].rd2; pc = vecs[i].pc; dmem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_pcsrc", i), 32'(PCSrc), 32'(vecs[i].e_pcsrc));
      check($sformatf("v%0d_flush", i), 32'(flush_out), 32'(vecs[i].e_pcsrc));
      check($sformatf("v%0d_target", i), PCtarget, vecs[i].e_tgt);
      check($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d_stall", i), 32'(stall_out), 32'd0);
      if (vecs[i].e_req) begin
        check($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].e_we));
        check($sformatf("v%0d_addr", i), dmem_addr, vecs[i].alu);
        check($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].rd2);
      end
      check($sformatf("v%0d_memdata", i), mem_data, vecs[i].alu);
      @(posedge clk); #1;
      check($sformatf("v%0d_regwrite_o", i), 32'(regwrite_o), 32'(vecs[i].e_rw));
      check($sformatf("v%0d_memtoreg_o", i), 32'(memtoreg_o), 32'(vecs[i].e_m2r));
      check($sformatf("v%0d_rd_o", i), 32'(rd_o), 32'(vecs[i].e_rd));
      check($sformatf("v%0d_readdata_o", i), readdata_o, vecs[i].e_rdat);
      check($sformatf("v%0d_alu_o", i), alu_o, vecs[i].e_alu);
    end
    check("tbl_stallcnt", stall_count, 32'd0);
    check("tbl_memerr", 32'(mem_error), 32'd0);

    // Store with 3 wait cycles
    @(negedge clk);
    idle_inputs();
    memwrite = 1; rd2 = 32'h12345678; alu = 32'h200;
    for (int c = 0; c < 4; c++) begin
      dmem_ready = (c == 3);
      #1;
      check($sformatf("st_stall%0d", c), 32'(stall_out), (c == 3) ? 32'd0 : 32'd1);
      check($sformatf("st_we%0d", c), 32'(dmem_we), 32'd1);
      check($sformatf("st_wdata%0d", c), dmem_wdata, 32'h12345678);
      @(posedge clk); #1;
      check($sformatf("st_regwrite%0d", c), 32'(regwrite_o), 32'd0);
      @(negedge clk);
    end
    check("st_stallcnt", stall_count, 32'd3);

    // Load with 2 wait cycles: bubbles then data
    idle_inputs();
    memread = 1; regwrite = 1; memtoreg = 1; rd = 9; alu = 32'h300;
    for (int c = 0; c < 3; c++) begin
      dmem_ready = (c == 2);
      dmem_rdata = (c == 2) ? 32'hCAFEF00D : 32'hBAD0BAD0;
      @(posedge clk); #1;
      check($sformatf("ld_regwrite%0d", c), 32'(regwrite_o), (c == 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("ld_readdata", readdata_o, 32'hCAFEF00D);
    check("ld_rd", 32'(rd_o), 32'd9);
    check("ld_stallcnt", stall_count, 32'd5);

    // Timeout: ready never arrives
    idle_inputs();
    memread = 1; regwrite = 1; rd = 6; dmem_rdata = 32'h11111111;
    count_stalls(n);
    check("to_stalls", 32'(n), 32'd15);
    check("to_memerr_before", 32'(mem_error), 32'd0);
    @(posedge clk); #1;
    check("to_readdata", readdata_o, 32'd0);
    check("to_regwrite", 32'(regwrite_o), 32'd1);
    check("to_memerr", 32'(mem_error), 32'd1);
    check("to_stallcnt", stall_count, 32'd20);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check("to_memerr_sticky", 32'(mem_error), 32'd1);

    // Reset mid-WAIT, then a fresh request must see the full timeout again
    memread = 1; regwrite = 1; rd = 3; alu = 32'h44;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    check("rw_req", 32'(dmem_req), 32'd0);
    check("rw_stall", 32'(stall_out), 32'd0);
    check("rw_regwrite", 32'(regwrite_o), 32'd0);
    check("rw_rd", 32'(rd_o), 32'd0);
    check("rw_alu", alu_o, 32'd0);
    check("rw_memerr", 32'(mem_error), 32'd0);
    check("rw_stallcnt", stall_count, 32'd0);
    @(negedge clk);
    reset = 1;
    count_stalls(n);
    check("rw_stalls_after", 32'(n), 32'd15);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage placed directly downstream of the EX stage (EX/MEM register). It resolves branches and jumps, performs word loads/stores through a handshaked data-memory port with bounded wait and a stall request, and drives the MEM/WB pipeline register consumed by write-back. It also exports the forwarding value fed back to the EX-stage operand muxes.

## Interface
- TIMEOUT, 16, maximum cycles a memory request may wait for `dmem_ready` before forced completion (≥2)
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0, released synchronously by the environment)
- Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in  in  1 each  EX/MEM control bits
- Zero_in, jal_in, jalr_in  in  1 each  ALU zero flag, jump flags
- Rd_in  in  5  destination register
- ALUresult_in, PCimm_in, ReadData2_in, PC_in  in  32 each  ALU result / address, branch target, store data, instruction PC
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr, dmem_wdata  out  32 each  word address (ALUresult_in), store data
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- dmem_ready  in  1  request accepted/completed this cycle
- PCSrc  out  1  redirect fetch
- PCtarget  out  32  redirect address
- flush_out  out  1  squash IF/ID and ID/EX
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_data  out  32  forwarding value (= ALUresult_in, combinational)
- Ctl_MemtoReg_out, Ctl_RegWrite_out  out  1 each  MEM/WB controls
- Rd_out  out  5
- ReadData_out, ALUresult_out  out  32 each  load data, ALU/link value
- mem_error  out  1  sticky timeout flag
- stall_count  out  32  saturating count of stalled cycles

## Operation
- mem_op = Ctl_MemRead_in | Ctl_MemWrite_in. Both set: treated as write, ReadData_out = 0.
- dmem_req = mem_op & (state==IDLE | state==WAIT); dmem_we = Ctl_MemWrite_in; addr/wdata driven combinationally from inputs.
- FSM states: IDLE, WAIT.
  - IDLE: dmem_req & !dmem_ready → WAIT, wait_cnt←1. dmem_req & dmem_ready → stay IDLE, access completes.
  - WAIT: dmem_ready → IDLE, completes. !dmem_ready & wait_cnt==TIMEOUT-1 → IDLE, forced completion, mem_error←1. Otherwise wait_cnt+1.
- stall_out = dmem_req & !dmem_ready & !(state==WAIT & wait_cnt==TIMEOUT-1).
- Upstream holds EX/MEM inputs stable while stall_out=1.
- MEM/WB register (clocked each edge):
  - stall_out=1: bubble — Ctl_RegWrite_out←0, Ctl_MemtoReg_out←0; other fields don't-care.
  - else: controls, Rd_out ← inputs; ReadData_out ← dmem_rdata on completed read, 0 on forced completion or non-read; ALUresult_out ← (jal_in|jalr_in) ? PC_in+4 : ALUresult_in (32-bit wrap).
- Branch resolution (combinational): PCSrc = (Ctl_Branch_in & Zero_in) | jal_in | jalr_in; PCtarget = jalr_in ? {ALUresult_in[31:1],1'b0} : PCimm_in; flush_out = PCSrc.
- stall_count increments on each cycle with stall_out=1, saturates at 0xFFFFFFFF.
- mem_error cleared only by reset.

## Timing
- Reset (async, reset=0): state=IDLE, wait_cnt=0, all MEM/WB outputs 0, mem_error=0, stall_count=0. dmem_req, stall_out, PCSrc, flush_out derive from inputs but dmem_req and stall_out forced 0 while reset=0. Reset mid-WAIT abandons the request immediately.
- Zero-wait access: request cycle N with dmem_ready=1 → no stall, MEM/WB updated at edge ending N.
- k-wait access (ready first high in cycle N+k, k<TIMEOUT): stall_out=1 for cycles N..N+k-1, MEM/WB bubbles at those edges, data latched at edge ending N+k.
- Timeout: stall_out=1 for exactly TIMEOUT-1 cycles; completion in cycle N+TIMEOUT-1; mem_error visible from following cycle.
- Branch/jump: PCSrc, PCtarget, flush_out valid same cycle as inputs (0 latency); instructions with Ctl_Branch/jal/jalr never issue memory requests.

## Test plan
- Reset: drive reset=0 mid-WAIT → dmem_req=0, stall_out=0, all registered outputs 0, state IDLE after release.
- Load, zero wait: MemRead=1, ALUresult_in=0x100, dmem_ready=1, dmem_rdata=0xDEADBEEF, Rd=5 → next cycle ReadData_out=0xDEADBEEF, Rd_out=5, RegWrite_out=1, stall_count=0.
- Store, 3 wait cycles: MemWrite=1, ReadData2_in=0x12345678 → dmem_we=1, dmem_wdata=0x12345678 held 4 cycles, stall_out=1 for 3, stall_count=3, RegWrite_out=0 throughout.
- Timeout: MemRead=1, dmem_ready held 0, TIMEOUT=16 → stall_out=1 for 15 cycles, then ReadData_out=0, mem_error=1 sticky.
- Branch taken: Branch=1, Zero=1, PCimm_in=0x40 → PCSrc=1, PCtarget=0x40, flush_out=1; Zero=0 → PCSrc=0.
- jalr: jalr_in=1, ALUresult_in=0x203, PC_in=0x80 → PCtarget=0x202, next cycle ALUresult_out=0x84.
